// File: rtl/io_read_port_responder_pkg.sv
// Shared constants and helpers for the I/O read-port responder and its
// write-side counterpart.
package io_read_port_responder_pkg;

    // Every port buffer is a fixed two-entry FIFO.
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned COUNT_WIDTH = 2;

    localparam logic [COUNT_WIDTH-1:0] COUNT_EMPTY = 2'd0;
    localparam logic [COUNT_WIDTH-1:0] COUNT_FULL  = 2'd2;

    // Empty/full bit encoding seen by the pipeline.
    localparam logic EF_DATA  = 1'b1;
    localparam logic EF_EMPTY = 1'b0;

    // Widest request vector the priority helper handles.
    localparam int unsigned MAX_PORTS = 32;

    // Isolate the lowest set bit of a request vector (one-hot or zero result).
    function automatic logic [MAX_PORTS-1:0] lowest_set_onehot(
        input logic [MAX_PORTS-1:0] req
    );
        return req & (~req + {{(MAX_PORTS-1){1'b0}}, 1'b1});
    endfunction

endpackage

// File: rtl/io_read_port_responder_fifo2.sv
// Two-entry FIFO buffering producer words for one read port.
module io_port_fifo2
    import io_read_port_responder_pkg::*;
#(
    parameter int unsigned WordWidth = 36
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WordWidth-1:0]   data_i,
    output logic [WordWidth-1:0]   head_o,
    output logic [COUNT_WIDTH-1:0] count_o,
    output logic                   ready_o,
    output logic                   ef_o
);

    logic [WordWidth-1:0]   mem_q [FIFO_DEPTH];
    logic [WordWidth-1:0]   mem_d [FIFO_DEPTH];
    logic                   wr_ptr_q, wr_ptr_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   push_ok;
    logic                   pop_ok;

    // Handshake qualification and status outputs, all from registered state.
    always_comb begin
        ready_o = (count_q < COUNT_FULL) & ~rst_i;
        push_ok = push_i & ready_o;
        pop_ok  = pop_i & (count_q != COUNT_EMPTY);
        head_o  = mem_q[rd_ptr_q];
        count_o = count_q;
        ef_o    = (count_q != COUNT_EMPTY) ? EF_DATA : EF_EMPTY;
    end

    // Next-state for storage, wrap-around pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Control state resets; stale storage is harmless since count gates it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= COUNT_EMPTY;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage registers, written only on an accepted push.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/io_read_port_responder.sv
// Peripheral endpoint of the CPU I/O read ports: per-port buffering, strobe
// priority select, registered read data and sticky error flags.
module io_read_port_responder #(
    parameter int unsigned WORD_WIDTH  = 36,
    parameter int unsigned PORT_COUNT  = 4,
    parameter int unsigned FIFO_DEPTH  = 2,
    parameter int unsigned COUNT_WIDTH = 2
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [PORT_COUNT-1:0]            active,
    output logic [WORD_WIDTH-1:0]            cpu_data,
    output logic                             cpu_data_valid,
    output logic [PORT_COUNT-1:0]            cpu_ef,
    input  logic [PORT_COUNT*WORD_WIDTH-1:0] in_data,
    input  logic [PORT_COUNT-1:0]            in_valid,
    output logic [PORT_COUNT-1:0]            in_ready,
    output logic [PORT_COUNT-1:0]            underrun,
    output logic                             multi_hit
);
    import io_read_port_responder_pkg::*;

    // Buffer geometry is fixed; reject anything else at elaboration.
    if (FIFO_DEPTH != io_read_port_responder_pkg::FIFO_DEPTH) begin : g_bad_depth
        $error("io_read_port_responder: FIFO_DEPTH must be 2");
    end
    if (COUNT_WIDTH != io_read_port_responder_pkg::COUNT_WIDTH) begin : g_bad_count
        $error("io_read_port_responder: COUNT_WIDTH must be 2");
    end
    if (PORT_COUNT > MAX_PORTS || PORT_COUNT == 0) begin : g_bad_ports
        $error("io_read_port_responder: PORT_COUNT out of range");
    end

    logic [WORD_WIDTH-1:0]  port_head  [PORT_COUNT];
    logic [COUNT_WIDTH-1:0] port_count [PORT_COUNT];

    logic [MAX_PORTS-1:0]  active_ext;
    logic [MAX_PORTS-1:0]  served_ext;
    logic [PORT_COUNT-1:0] served;
    logic [PORT_COUNT-1:0] pop_en;
    logic [PORT_COUNT-1:0] empty_hit;

    logic [WORD_WIDTH-1:0] cpu_data_q, cpu_data_d;
    logic                  cpu_data_valid_q, cpu_data_valid_d;
    logic [PORT_COUNT-1:0] underrun_q, underrun_d;
    logic                  multi_hit_q, multi_hit_d;

    assign active_ext = MAX_PORTS'(active);
    assign served_ext = lowest_set_onehot(active_ext);
    assign served     = served_ext[PORT_COUNT-1:0];

    // Upper priority bits are always zero for a narrower strobe vector.
    if (PORT_COUNT < MAX_PORTS) begin : g_served_hi
        logic unused_served_hi;
        assign unused_served_hi = ^served_ext[MAX_PORTS-1:PORT_COUNT];
    end

    for (genvar g = 0; g < PORT_COUNT; g++) begin : g_port
        io_port_fifo2 #(
            .WordWidth (WORD_WIDTH)
        ) u_fifo (
            .clk_i   (clock),
            .rst_i   (reset),
            .push_i  (in_valid[g]),
            .pop_i   (pop_en[g]),
            .data_i  (in_data[g*WORD_WIDTH +: WORD_WIDTH]),
            .head_o  (port_head[g]),
            .count_o (port_count[g]),
            .ready_o (in_ready[g]),
            .ef_o    (cpu_ef[g])
        );
    end

    // Served port pops if it holds data, otherwise it records an underrun.
    always_comb begin
        pop_en    = '0;
        empty_hit = '0;
        for (int i = 0; i < PORT_COUNT; i++) begin
            if (served[i]) begin
                if (port_count[i] != COUNT_EMPTY) begin
                    pop_en[i] = 1'b1;
                end else begin
                    empty_hit[i] = 1'b1;
                end
            end
        end
    end

    // Next read word (one-hot mux of the popped head) and sticky flags.
    always_comb begin
        cpu_data_d = '0;
        for (int i = 0; i < PORT_COUNT; i++) begin
            if (pop_en[i]) begin
                cpu_data_d = cpu_data_d | port_head[i];
            end
        end
        cpu_data_valid_d = |pop_en;
        underrun_d       = underrun_q | empty_hit;
        // Any strobe bit beyond the served one means several were raised.
        multi_hit_d      = multi_hit_q | (|(active & ~served));
    end

    // Output register and sticky flags, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            cpu_data_q       <= '0;
            cpu_data_valid_q <= 1'b0;
            underrun_q       <= '0;
            multi_hit_q      <= 1'b0;
        end else begin
            cpu_data_q       <= cpu_data_d;
            cpu_data_valid_q <= cpu_data_valid_d;
            underrun_q       <= underrun_d;
            multi_hit_q      <= multi_hit_d;
        end
    end

    assign cpu_data       = cpu_data_q;
    assign cpu_data_valid = cpu_data_valid_q;
    assign underrun       = underrun_q;
    assign multi_hit      = multi_hit_q;

endmodule

// File: tb/tb_io_read_port_responder.sv
// Self-checking bench: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_io_read_port_responder;

    localparam int W = 36;
    localparam int P = 4;

    logic           clock = 1'b0;
    logic           reset;
    logic [P-1:0]   active;
    logic [W-1:0]   cpu_data;
    logic           cpu_data_valid;
    logic [P-1:0]   cpu_ef;
    logic [P*W-1:0] in_data;
    logic [P-1:0]   in_valid;
    logic [P-1:0]   in_ready;
    logic [P-1:0]   underrun;
    logic           multi_hit;

    always #5 clock = ~clock;

    io_read_port_responder #(
        .WORD_WIDTH  (W),
        .PORT_COUNT  (P),
        .FIFO_DEPTH  (2),
        .COUNT_WIDTH (2)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .active         (active),
        .cpu_data       (cpu_data),
        .cpu_data_valid (cpu_data_valid),
        .cpu_ef         (cpu_ef),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .underrun       (underrun),
        .multi_hit      (multi_hit)
    );

    // Reference model state.
    logic [W-1:0] mq [P][$];
    logic [W-1:0] exp_data = '0;
    logic         exp_valid = 1'b0;
    logic [P-1:0] exp_underrun = '0;
    logic         exp_multi = 1'b0;

    int checks = 0;
    int failures = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    // Apply one clock edge of the behavioural rules to the model.
    task automatic model_step();
        logic [P-1:0] room;
        int sel;
        if (reset) begin
            for (int i = 0; i < P; i++) mq[i].delete();
            exp_data     = '0;
            exp_valid    = 1'b0;
            exp_underrun = '0;
            exp_multi    = 1'b0;
        end else begin
            for (int i = 0; i < P; i++) room[i] = (mq[i].size() < 2);
            sel = -1;
            for (int i = P - 1; i >= 0; i--) if (active[i]) sel = i;
            exp_data  = '0;
            exp_valid = 1'b0;
            if (sel >= 0) begin
                if (mq[sel].size() > 0) begin
                    exp_data  = mq[sel].pop_front();
                    exp_valid = 1'b1;
                end else begin
                    exp_underrun[sel] = 1'b1;
                end
            end
            if ($countones(active) > 1) exp_multi = 1'b1;
            for (int i = 0; i < P; i++)
                if (in_valid[i] && room[i]) mq[i].push_back(in_data[i*W +: W]);
        end
    endtask

    // Compare every DUT output against the model once per cycle.
    always @(negedge clock) begin
        if (check_en) begin
            logic [P-1:0] ef_m;
            logic [P-1:0] rdy_m;
            for (int i = 0; i < P; i++) begin
                ef_m[i]  = (mq[i].size() != 0);
                rdy_m[i] = !reset && (mq[i].size() < 2);
            end
            check("cpu_data", 64'(cpu_data), 64'(exp_data));
            check("cpu_data_valid", 64'(cpu_data_valid), 64'(exp_valid));
            check("cpu_ef", 64'(cpu_ef), 64'(ef_m));
            check("in_ready", 64'(in_ready), 64'(rdy_m));
            check("underrun", 64'(underrun), 64'(exp_underrun));
            check("multi_hit", 64'(multi_hit), 64'(exp_multi));
        end
    end

    task automatic drive(input logic rst, input logic [P-1:0] act, input logic [P-1:0] vld,
                         input logic [W-1:0] d0, input logic [W-1:0] d1,
                         input logic [W-1:0] d2, input logic [W-1:0] d3);
        reset            = rst;
        active           = act;
        in_valid         = vld;
        in_data[0*W +: W] = d0;
        in_data[1*W +: W] = d1;
        in_data[2*W +: W] = d2;
        in_data[3*W +: W] = d3;
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 4'b0000, 4'b0000, '0, '0, '0, '0);
    endtask

    task automatic settle();
        @(negedge clock);
        #1;
    endtask

    initial begin
        logic [63:0] r0, r1, r2, r3;
        logic [P-1:0] act_r;
        logic rst_r;
        reset    = 1'b1;
        active   = '0;
        in_valid = '0;
        in_data  = '0;

        drive(1'b1, 4'b0000, 4'b0000, '0, '0, '0, '0);
        check_en = 1'b1;
        drive(1'b1, 4'b0000, 4'b0000, '0, '0, '0, '0);
        settle();
        check("rst_ready", 64'(in_ready), 64'h0);
        check("rst_valid", 64'(cpu_data_valid), 64'h0);
        check("rst_data", 64'(cpu_data), 64'h0);

        // 1: single push to port 2, then pop it.
        drive(1'b0, 4'b0000, 4'b0100, '0, '0, 36'h0_0000_00AA, '0);
        settle();
        check("t1_ef_after_push", 64'(cpu_ef), 64'h4);
        check("t1_ready", 64'(in_ready), 64'hF);
        drive(1'b0, 4'b0100, 4'b0000, '0, '0, '0, '0);
        settle();
        check("t1_data", 64'(cpu_data), 64'hAA);
        check("t1_valid", 64'(cpu_data_valid), 64'h1);
        check("t1_ef_after_pop", 64'(cpu_ef), 64'h0);

        // 2: fill port 0, third word held off, pops come out in order.
        drive(1'b0, 4'b0000, 4'b0001, 36'h111, '0, '0, '0);
        drive(1'b0, 4'b0000, 4'b0001, 36'h222, '0, '0, '0);
        settle();
        check("t2_ready_full", 64'(in_ready[0]), 64'h0);
        drive(1'b0, 4'b0000, 4'b0001, 36'h999, '0, '0, '0);
        drive(1'b0, 4'b0001, 4'b0000, '0, '0, '0, '0);
        settle();
        check("t2_first", 64'(cpu_data), 64'h111);
        drive(1'b0, 4'b0001, 4'b0000, '0, '0, '0, '0);
        settle();
        check("t2_second", 64'(cpu_data), 64'h222);
        check("t2_empty", 64'(cpu_ef[0]), 64'h0);

        // 3: push and pop on port 1 in the same cycle with one word held.
        drive(1'b0, 4'b0000, 4'b0010, '0, 36'h333, '0, '0);
        drive(1'b0, 4'b0010, 4'b0010, '0, 36'h444, '0, '0);
        settle();
        check("t3_data", 64'(cpu_data), 64'h333);
        check("t3_ef", 64'(cpu_ef[1]), 64'h1);
        drive(1'b0, 4'b0010, 4'b0000, '0, '0, '0, '0);
        settle();
        check("t3_next", 64'(cpu_data), 64'h444);

        // 4: strobe an empty port.
        drive(1'b0, 4'b1000, 4'b0000, '0, '0, '0, '0);
        settle();
        check("t4_valid", 64'(cpu_data_valid), 64'h0);
        check("t4_data", 64'(cpu_data), 64'h0);
        check("t4_underrun", 64'(underrun), 64'h8);
        idle();
        idle();
        idle();
        settle();
        check("t4_sticky", 64'(underrun), 64'h8);

        // 5: two strobe bits, only port 0 served.
        drive(1'b0, 4'b0000, 4'b0101, 36'h555, '0, 36'h666, '0);
        drive(1'b0, 4'b0101, 4'b0000, '0, '0, '0, '0);
        settle();
        check("t5_data", 64'(cpu_data), 64'h555);
        check("t5_multi", 64'(multi_hit), 64'h1);
        check("t5_ef", 64'(cpu_ef), 64'h4);
        check("t5_no_underrun", 64'(underrun), 64'h8);
        drive(1'b0, 4'b0100, 4'b0000, '0, '0, '0, '0);
        settle();
        check("t5_port2", 64'(cpu_data), 64'h666);

        // 6: reset mid-stream discards data and flags.
        drive(1'b0, 4'b0000, 4'b0010, '0, 36'h777, '0, '0);
        drive(1'b0, 4'b0000, 4'b0010, '0, 36'h888, '0, '0);
        drive(1'b1, 4'b0000, 4'b0000, '0, '0, '0, '0);
        settle();
        check("t6_ready_in_reset", 64'(in_ready), 64'h0);
        check("t6_ef", 64'(cpu_ef), 64'h0);
        check("t6_underrun", 64'(underrun), 64'h0);
        check("t6_multi", 64'(multi_hit), 64'h0);
        idle();
        settle();
        check("t6_ready_after", 64'(in_ready), 64'hF);
        drive(1'b0, 4'b0010, 4'b0000, '0, '0, '0, '0);
        settle();
        check("t6_pop_underrun", 64'(underrun), 64'h2);
        check("t6_pop_valid", 64'(cpu_data_valid), 64'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            r0 = {$urandom, $urandom};
            r1 = {$urandom, $urandom};
            r2 = {$urandom, $urandom};
            r3 = {$urandom, $urandom};
            case ($urandom_range(0, 9))
                0, 1, 2: act_r = '0;
                8:       act_r = 4'($urandom_range(0, 15));
                default: act_r = 4'(1 << $urandom_range(0, P - 1));
            endcase
            rst_r = ($urandom_range(0, 149) == 0);
            drive(rst_r, act_r, 4'($urandom_range(0, 15)), r0[W-1:0], r1[W-1:0],
                  r2[W-1:0], r3[W-1:0]);
        end
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_read_port_responder.md
Name: io_read_port_responder

Overview:
Peripheral-side endpoint of the CPU's I/O read ports. It buffers words from external producers in one small FIFO per port. It answers the registered one-hot "active" read strobes that the core's I/O address decode raises. It returns the selected word to the datapath one cycle later and publishes per-port empty/full (EF) bits so the pipeline can predict port readiness.

Parameters:
WORD_WIDTH, 36, data word width
PORT_COUNT, 4, number of read ports served
FIFO_DEPTH, 2, entries per port; fixed at 2, any other value is an elaboration error
COUNT_WIDTH, 2, occupancy counter width (holds 0..FIFO_DEPTH)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
active  in  PORT_COUNT  one-hot read strobe from the core's I/O address decode
cpu_data  out  WORD_WIDTH  word returned to the datapath, registered
cpu_data_valid  out  1  high for one cycle when cpu_data holds a real pop
cpu_ef  out  PORT_COUNT  1 = port holds at least one word
in_data  in  PORT_COUNT*WORD_WIDTH  producer words; port i occupies bits [i*WORD_WIDTH +: WORD_WIDTH]
in_valid  in  PORT_COUNT  producer word valid, per port
in_ready  out  PORT_COUNT  responder can accept a word, per port
underrun  out  PORT_COUNT  sticky: port was strobed while empty
multi_hit  out  1  sticky: active had more than one bit set

Behaviour:
- Reset (synchronous, active-high) sets:
  - all occupancy counts and read/write pointers to 0
  - cpu_data = 0, cpu_data_valid = 0
  - underrun = 0, multi_hit = 0
  - in_ready = 0 while reset is high
- Per-port FIFO:
  - 2 entries, wrap-around pointers, count 0..2.
  - in_ready[i] = (count_i < 2) & ~reset. It depends only on registered state, never on in_valid.
- Push: in_valid[i] & in_ready[i] writes in_data slice i at the write pointer; the count increments at the clock edge.
- Pop: at most one port per cycle.
  - The served port is the lowest-index set bit of active.
  - A pop occurs if that port's count > 0.
- Simultaneous push and pop on the same port, same cycle:
  - count 1 → stays 1.
  - count 2 → in_ready is 0, so pop only, count → 1.
  - count 0 → pop impossible; push proceeds, count → 1, and underrun[i] is set. The word pushed that cycle is NOT bypassed.
- Latency: the strobe in cycle N produces cpu_data and cpu_data_valid in cycle N+1.
  - cpu_data = the head word of the served port as sampled in cycle N.
  - On underrun or no strobe: cpu_data_valid = 0 and cpu_data = 0.
- cpu_ef[i] = (count_i != 0), taken from registered state. It reflects a pop or push one cycle after the edge that caused it.
- Multiple bits in active:
  - Only the lowest index is served.
  - The other ports are untouched (no pop, no underrun).
  - multi_hit is set.
- Sticky flags clear only on reset.
- Reset mid-operation: buffered words are discarded. A producer holding in_valid retries when in_ready returns.
- Ports with active = 0 and in_valid = 0 hold their state indefinitely.

Decomposition:
- Shared package holds:
  - FIFO_DEPTH = 2 and COUNT_WIDTH = 2 constants
  - the EF encoding (1 = data present)
  - the lowest-set-bit priority function, reused by the write-side counterpart
- Sub-module io_port_fifo2: one 2-entry FIFO with push/pop, count, head, ready and ef outputs. It is instantiated PORT_COUNT times.
- Priority select, output register and sticky flags live in the top level.

Test Plan:
1. Reset, then in_valid[2] = 1 with in_data slice 2 = 36'h0_0000_00AA for 1 cycle → cpu_ef = 4'b0100 next cycle. Then active = 4'b0100 → next cycle cpu_data = 36'h0AA, cpu_data_valid = 1, cpu_ef = 4'b0000.
2. Push 36'h111 then 36'h222 to port 0; in_ready[0] = 0 after the second push; a third in_valid is held off. Pop twice → cpu_data 36'h111 then 36'h222, in order.
3. Port 1 count = 1 (word 36'h333), then push 36'h444 and active = 4'b0010 in the same cycle → cpu_data = 36'h333, count stays 1, next pop returns 36'h444.
4. active = 4'b1000 with port 3 empty → cpu_data_valid = 0, cpu_data = 0, underrun = 4'b1000 and stays set until reset.
5. Ports 0 and 2 both hold data, active = 4'b0101 → port 0 popped, port 2 count unchanged, multi_hit = 1.
6. Fill port 1 to 2 words, assert reset for 1 cycle mid-stream → all cpu_ef = 0, in_ready = 0 during reset and 4'b1111 after, flags = 0, and a subsequent pop reports underrun.
